sfifo_split_chain: RTL and testbench
====================================

# sfifo_split_chain

Single-clock, parametrised ready/valid FIFO built as a chain of SPLIT_WAYS equal segments, successor to the dual-clock split wrapper for paths that stay in one clock domain. Adds a global occupancy count, a programmable almost-full flag, an empty flag and a synchronous flush. It sits between streaming producers and consumers in the accelerator datapath, where the segmenting keeps each storage array small enough for MLAB/register mapping and eases placement across long routes.

## Interface
- DATA_WIDTH, 32, payload width in bits.
- FIFO_DEPTH_LOG2, 6, log2 of total capacity DEPTH = 2^FIFO_DEPTH_LOG2.
- SPLIT_WAYS, 2, number of chained segments. Must be a power of two, 1..DEPTH/2.
- ALMOST_FULL_THRESH, DEPTH-4, almost_full asserts when count >= this value. Range 1..DEPTH.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- wr_valid  in  1  producer has data.
- wr_ready  out  1  FIFO accepts data.
- wr_data  in  DATA_WIDTH  write payload.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer takes data.
- rd_data  out  DATA_WIDTH  read payload.
- count  out  FIFO_DEPTH_LOG2+1  total entries held across all segments.
- almost_full  out  1  count >= ALMOST_FULL_THRESH.
- empty  out  1  count == 0.

## Operation
- Segment depth SEG_DEPTH = DEPTH/SPLIT_WAYS (>= 2). Each segment is a circular buffer with read/write pointers of width log2(SEG_DEPTH)+1. Full when pointer MSBs differ and low bits match; empty when pointers are equal.
- Segment k output valid = !empty_k; segment k output ready = !full_(k+1). The last segment uses rd_ready. Segment 0 write ready is wr_ready.
- Segment read data is combinational from the head entry (first-word-fall-through at each segment boundary). Writes land at the clock edge.
- wr_ready = !full_0 && !flush. No write-through when full: a simultaneous pop does not open space in the same cycle.
- rd_valid = !empty_last && !flush.
- count: +1 on write handshake only, -1 on read handshake only, unchanged when both or neither occur. Inter-segment transfers do not change count. count never exceeds DEPTH.
- almost_full and empty are combinational from the registered count.
- flush: while flush is high, wr_ready = 0, rd_valid = 0, and no handshakes or inter-segment transfers occur. On the edge, all pointers reset and count becomes 0. Data is not cleared.
- Elaboration checks fail with $error if SPLIT_WAYS is not a power of two, SEG_DEPTH < 2, or ALMOST_FULL_THRESH is outside 1..DEPTH.
- Order is strictly preserved and no entry is ever duplicated or dropped, except by flush or reset.

## Timing
- Reset, while rst_n is low and after it: rd_valid 0, wr_ready 0 while rst_n is low then 1, count 0, empty 1, almost_full 0, all pointers 0. rd_data is don't-care.
- Reset asserted mid-operation discards contents immediately (asynchronous).
- Empty-FIFO latency: a word written on edge t is at segment 1 on edge t+1 and shows rd_valid after edge t+SPLIT_WAYS-1. With SPLIT_WAYS=1, rd_valid is high one cycle after the write.
- Throughput is one word per cycle sustained when rd_ready is held high.
- count, empty and almost_full update one edge after the handshake.
- With rd_ready=0, DEPTH consecutive writes are all accepted; wr_ready drops the cycle after the DEPTH-th write.

## Test plan
- Latency: DATA_WIDTH=8, FIFO_DEPTH_LOG2=4, SPLIT_WAYS=2, rd_ready=1; write 0xA5 at cycle 0 -> rd_valid=1 with rd_data=0xA5 at cycle 2, count 1 then 0, empty back to 1.
- Fill/drain: same config, rd_ready=0, write 0x00..0x0F back to back -> all 16 accepted, wr_ready=0 after, count=16, almost_full=1 (THRESH=12) from count 12. Then rd_ready=1 -> 0x00..0x0F out in order, one per cycle, wr_ready=1 after the first pop.
- Streaming: SPLIT_WAYS=4, FIFO_DEPTH_LOG2=6, random wr_valid/rd_ready at 50% over 10k cycles -> scoreboard order exact, count matches model every cycle, count <= 64.
- Simultaneous push/pop: full FIFO, wr_valid=1, rd_ready=1 -> pop occurs and push is refused that cycle (count 16->15). Half-full with both handshakes -> count unchanged.
- Flush: 9 entries held, flush pulse with wr_valid=1 and rd_ready=1 -> no handshake that cycle, next cycle count=0, empty=1, rd_valid=0. A fresh write of 0x3C emerges as the first output.
- Reset mid-stream: drop rst_n asynchronously between edges with 7 entries held -> outputs take reset values immediately. After release, no stale data appears and count=0.

Source files
------------

// File: rtl/sfifo_split_chain.sv
// -----------------------------------------------------------------------------
// sfifo_split_chain
//   Single-clock ready/valid FIFO built from SPLIT_WAYS chained circular-buffer
//   segments of DEPTH/SPLIT_WAYS entries each. Words enter segment 0 and move
//   one segment per clock towards the last segment, whose head is the read
//   port. A global occupancy count tracks words accepted minus words read,
//   regardless of where in the chain they currently sit.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset (pointers and count cleared)
//   flush        synchronous clear: pointers and count to zero, data kept
//   wr_valid     producer has a word on wr_data
//   wr_ready     FIFO accepts the word (segment 0 not full, no flush)
//   wr_data      write payload
//   rd_valid     last segment holds a word and no flush is in progress
//   rd_ready     consumer takes rd_data
//   rd_data      head word of the last segment (don't-care when !rd_valid)
//   count        total words held across all segments
//   almost_full  count >= ALMOST_FULL_THRESH
//   empty        count == 0
// -----------------------------------------------------------------------------
module sfifo_split_chain #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH_LOG2    = 6,
    parameter int SPLIT_WAYS         = 2,
    parameter int ALMOST_FULL_THRESH = (1 << FIFO_DEPTH_LOG2) - 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [FIFO_DEPTH_LOG2:0] count,
    output logic                     almost_full,
    output logic                     empty
);

    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam int SEG_DEPTH = DEPTH / SPLIT_WAYS;
    // Clamp keeps the pointer slices legal so the elaboration error below is
    // the reported problem rather than a negative-range slice.
    localparam int SEG_LOG2  = (SEG_DEPTH < 2) ? 1 : $clog2(SEG_DEPTH);
    localparam int PTR_W     = SEG_LOG2 + 1;
    localparam int CNT_W     = FIFO_DEPTH_LOG2 + 1;
    localparam int LAST      = SPLIT_WAYS - 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(ALMOST_FULL_THRESH);

    // ---------------------------------------------------------------------
    // Parameter sanity
    // ---------------------------------------------------------------------
    if ((SPLIT_WAYS < 1) || ((SPLIT_WAYS & (SPLIT_WAYS - 1)) != 0)) begin : g_chk_ways
        $error("sfifo_split_chain: SPLIT_WAYS must be a power of two");
    end
    if (SEG_DEPTH < 2) begin : g_chk_seg
        $error("sfifo_split_chain: segment depth DEPTH/SPLIT_WAYS must be >= 2");
    end
    if ((ALMOST_FULL_THRESH < 1) || (ALMOST_FULL_THRESH > DEPTH)) begin : g_chk_thresh
        $error("sfifo_split_chain: ALMOST_FULL_THRESH must lie in 1..DEPTH");
    end

    // ---------------------------------------------------------------------
    // Chain-wide signals. Push/pop live in separate vectors so that no
    // vector feeds back into itself combinationally.
    // ---------------------------------------------------------------------
    logic [SPLIT_WAYS-1:0] seg_full_s;
    logic [SPLIT_WAYS-1:0] seg_empty_s;
    logic [SPLIT_WAYS-1:0] seg_push_s;
    logic [SPLIT_WAYS-1:0] seg_pop_s;
    logic [DATA_WIDTH-1:0] seg_head_s [SPLIT_WAYS];
    logic                  wr_hs_s;
    logic                  rd_hs_s;
    logic [CNT_W-1:0]      count_r;

    // rst_n gates wr_ready so the producer sees "not ready" for the whole
    // reset window, not just from the first edge.
    assign wr_ready = rst_n && !seg_full_s[0] && !flush;
    assign wr_hs_s  = wr_valid && wr_ready;
    assign rd_valid = !seg_empty_s[LAST] && !flush;
    assign rd_hs_s  = seg_pop_s[LAST];
    assign rd_data  = seg_head_s[LAST];

    for (genvar k = 0; k < SPLIT_WAYS; k++) begin : g_seg
        logic [PTR_W-1:0]      wr_ptr_r;
        logic [PTR_W-1:0]      rd_ptr_r;
        logic [DATA_WIDTH-1:0] mem_r [SEG_DEPTH];
        logic [DATA_WIDTH-1:0] in_data_s;
        logic                  out_ready_s;

        if (k == 0) begin : g_in_head
            assign seg_push_s[k] = wr_hs_s;
            assign in_data_s     = wr_data;
        end else begin : g_in_chain
            assign seg_push_s[k] = seg_pop_s[k-1];
            assign in_data_s     = seg_head_s[k-1];
        end

        // Downstream ready looks only at the registered full flag, so a word
        // advances at most one segment per clock.
        if (k == LAST) begin : g_out_tail
            assign out_ready_s = rd_ready;
        end else begin : g_out_chain
            assign out_ready_s = !seg_full_s[k+1];
        end

        assign seg_full_s[k]  = (wr_ptr_r[SEG_LOG2] != rd_ptr_r[SEG_LOG2]) &&
                                (wr_ptr_r[SEG_LOG2-1:0] == rd_ptr_r[SEG_LOG2-1:0]);
        assign seg_empty_s[k] = (wr_ptr_r == rd_ptr_r);
        assign seg_pop_s[k]   = !seg_empty_s[k] && out_ready_s && !flush;
        assign seg_head_s[k]  = mem_r[rd_ptr_r[SEG_LOG2-1:0]];

        // Segment pointer state: async reset, flush rewinds both pointers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (seg_push_s[k]) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (seg_pop_s[k]) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
        end

        // Segment storage: no reset, contents are only meaningful between
        // the pointers.
        always_ff @(posedge clk) begin
            if (seg_push_s[k]) begin
                mem_r[wr_ptr_r[SEG_LOG2-1:0]] <= in_data_s;
            end
        end
    end

    // Global occupancy: only the outer handshakes move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (flush) begin
            count_r <= CNT_ZERO;
        end else begin
            case ({wr_hs_s, rd_hs_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count       = count_r;
    assign empty       = (count_r == CNT_ZERO);
    assign almost_full = (count_r >= AF_THRESH);

endmodule

// File: tb/tb_sfifo_split_chain.sv
// -----------------------------------------------------------------------------
// Testbench for sfifo_split_chain (8-bit, 16 deep, 2 segments, threshold 12).
// Reference model: one queue per segment, capacity DEPTH/SPLIT_WAYS, where a
// segment hands its head on when the next segment has room (decided on the
// state before the edge), plus an occupancy counter. Accepted words are also
// pushed into a scoreboard queue; an independent monitor pops it on every
// read handshake and compares rd_data.
// -----------------------------------------------------------------------------
module tb_sfifo_split_chain;

    localparam int DW     = 8;
    localparam int LOG2   = 4;
    localparam int SW     = 2;
    localparam int DEPTH  = 16;
    localparam int SEG    = DEPTH / SW;
    localparam int THRESH = 12;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          flush    = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [LOG2:0] count;
    logic          almost_full;
    logic          empty;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] seg_q [SW][$];
    int            m_count = 0;

    always #5 clk = ~clk;

    sfifo_split_chain #(
        .DATA_WIDTH        (DW),
        .FIFO_DEPTH_LOG2   (LOG2),
        .SPLIT_WAYS        (SW),
        .ALMOST_FULL_THRESH(THRESH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .count      (count),
        .almost_full(almost_full),
        .empty      (empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < SW; k++) seg_q[k].delete();
        exp_q.delete();
        m_count = 0;
    endtask

    // One clock of stimulus: drive after the falling edge, compare the
    // outputs against the model, then advance the model across the next edge.
    task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
        bit            m_wr;
        bit            m_rd;
        bit            mv [SW];
        logic [DW-1:0] d;
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
        m_wr = rst_n && !fl && (seg_q[0].size() < SEG);
        m_rd = !fl && (seg_q[SW-1].size() > 0);
        chk("wr_ready", wr_ready, m_wr);
        chk("rd_valid", rd_valid, m_rd);
        chk("count", count, m_count);
        chk("empty", empty, (m_count == 0));
        chk("almost_full", almost_full, (m_count >= THRESH));
        if (fl) begin
            model_clear();
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (k == SW - 1) mv[k] = (seg_q[k].size() > 0) && rr;
                else             mv[k] = (seg_q[k].size() > 0) && (seg_q[k+1].size() < SEG);
            end
            for (int k = SW - 1; k >= 0; k--) begin
                if (mv[k]) begin
                    d = seg_q[k].pop_front();
                    if (k < SW - 1) seg_q[k+1].push_back(d);
                end
            end
            if (wv && m_wr) begin
                seg_q[0].push_back(wd);
                exp_q.push_back(wd);
                m_count++;
            end
            if (mv[SW-1]) m_count--;
        end
    endtask

    // Look just after the next rising edge with inputs idled, against
    // constants worked out for the directed scenarios.
    task automatic after_edge(input string tag, input int cnt, input bit wrdy, input bit rvld);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        #1;
        chk({tag, "_count"}, count, cnt);
        chk({tag, "_wr_ready"}, wr_ready, wrdy);
        chk({tag, "_rd_valid"}, rd_valid, rvld);
        chk({tag, "_empty"}, empty, (cnt == 0));
        chk({tag, "_almost_full"}, almost_full, (cnt >= THRESH));
    endtask

    // Scoreboard monitor: every read handshake must deliver the oldest
    // accepted word still outstanding.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rd_valid && rd_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected: got %0h with nothing outstanding at %0t", rd_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        bad++;
                        $display("FAIL rd_data: got %0h expected %0h at %0t", rd_data, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state while rst_n is low.
        #2;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_almost_full", almost_full, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Latency: one word through two segments.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        after_edge("lat0", 1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        after_edge("lat1", 1, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        after_edge("lat2", 0, 1'b1, 1'b0);

        // Fill to DEPTH with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        after_edge("fill", 16, 1'b0, 1'b1);

        // Full FIFO with both sides active: pop only.
        cycle(1'b1, 8'h99, 1'b1, 1'b0);
        after_edge("fullpp", 15, 1'b0, 1'b1);
        repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Half full with both sides active: count holds.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        after_edge("halfpp", 8, 1'b1, 1'b1);
        repeat (12) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with 9 words held, then a fresh word must come out first.
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b1);
        after_edge("flush", 0, 1'b1, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset between edges with 7 words held.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_ready", wr_ready, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_almost_full", almost_full, 0);
        model_clear();
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        after_edge("postrst", 0, 1'b1, 1'b0);

        // Random traffic with occasional flush, then drain.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 199) == 0));
        end
        repeat (40) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
